// File: rtl/decode_cycle.sv
// RISC-V decode stage: main/ALU decode, immediate generation, 32x32 register
// file with write-through, and the ID/EX pipeline register with flush.
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PcPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PcPlus4E
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } idex_t;

  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic [1:0]  imm_src, alu_op;
  logic [31:0] imm_ext;
  logic [31:0] rd1, rd2;
  logic [31:0] rf_q [1:31];
  idex_t       idex_d, idex_q;

  assign op     = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];

  // Main decoder; unknown opcodes fall through as an all-zero bubble.
  always_comb begin
    idex_d            = '0;
    imm_src           = IMM_I;
    alu_op            = 2'b00;
    unique case (op)
      7'b0000011: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.result_src = 2'b01;
      end
      7'b0100011: begin
        idex_d.mem_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      7'b0110011: begin
        idex_d.reg_write = 1'b1;
        alu_op           = 2'b10;
      end
      7'b1100011: begin
        idex_d.branch = 1'b1;
        imm_src       = IMM_B;
        alu_op        = 2'b01;
      end
      7'b0010011: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        alu_op           = 2'b10;
      end
      7'b1101111: begin
        idex_d.reg_write  = 1'b1;
        idex_d.jump       = 1'b1;
        idex_d.result_src = 2'b10;
        imm_src           = IMM_J;
      end
      default: ;
    endcase

    unique case (alu_op)
      2'b01:   idex_d.alu_ctrl = 3'b001;
      2'b10: begin
        unique case (funct3)
          3'b000:  idex_d.alu_ctrl = (op[5] && InstrD[30]) ? 3'b001 : 3'b000;
          3'b010:  idex_d.alu_ctrl = 3'b101;
          3'b110:  idex_d.alu_ctrl = 3'b011;
          3'b111:  idex_d.alu_ctrl = 3'b010;
          default: idex_d.alu_ctrl = 3'b000;
        endcase
      end
      default: idex_d.alu_ctrl = 3'b000;
    endcase

    idex_d.rd1 = rd1;
    idex_d.rd2 = rd2;
    idex_d.imm = imm_ext;
    idex_d.rs1 = rs1;
    idex_d.rs2 = rs2;
    idex_d.rd  = InstrD[11:7];
    idex_d.pc  = PCD;
    idex_d.pc4 = PcPlus4D;
  end

  always_comb begin
    unique case (imm_src)
      IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
    endcase
  end

  // Write-through lets the W-stage result reach ID/EX on the same edge it is written.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) rd1 = (RegWriteW && RDW == rs1) ? ResultW : rf_q[rs1];
    if (rs2 != 5'd0) rd2 = (RegWriteW && RDW == rs2) ? ResultW : rf_q[rs2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && RDW != 5'd0) begin
      rf_q[RDW] <= ResultW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idex_q <= '0;
    else if (FlushE) idex_q <= '0;
    else             idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PcPlus4E    = idex_q.pc4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle with hand-computed expectations.
module tb_decode_cycle;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PcPlus4D = '0, ResultW = '0;
  logic        RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0]  RDW = '0;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PcPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int errors = 0, checks = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PcPlus4D(PcPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .PCE(PCE), .PcPlus4E(PcPlus4E)
  );

  always #5 clk = ~clk;

  logic [8:0]   ctrl_e;
  logic [238:0] all_e;
  assign ctrl_e = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE[1:0]}
                  | {8'b0, ALUControlE[2]};
  assign all_e  = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
                   RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PcPlus4E};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (all_e !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", all_e); end
    rst = 1'b0;
  endtask

  task automatic test_itype();
    InstrD = 32'h00500093; PCD = 32'h10; PcPlus4D = 32'h14;
    tick();
    checks++;
    if ({RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, ResultSrcE} !== 7'b1100000) begin
      errors++; $display("FAIL itype_ctrl got=%b want=1100000", {RegWriteE, ALUSrcE, MemWriteE, JumpE, BranchE, ResultSrcE});
    end
    checks++;
    if (ImmExtE !== 32'd5 || RdE !== 5'd1 || ALUControlE !== 3'b000) begin
      errors++; $display("FAIL itype_imm_rd_alu got=%h/%0d/%b want=5/1/000", ImmExtE, RdE, ALUControlE);
    end
    checks++;
    if (PCE !== 32'h10 || PcPlus4E !== 32'h14) begin
      errors++; $display("FAIL itype_pc got=%h/%h want=10/14", PCE, PcPlus4E);
    end
  endtask

  task automatic test_write_through();
    RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'd5; InstrD = 32'h00000033;
    tick();
    RDW = 5'd2; ResultW = 32'd7; InstrD = 32'h402081B3; PCD = 32'h20; PcPlus4D = 32'h24;
    tick();
    checks++;
    if (RD1E !== 32'd5 || RD2E !== 32'd7) begin
      errors++; $display("FAIL wt_operands got=%0d/%0d want=5/7", RD1E, RD2E);
    end
    checks++;
    if (ALUControlE !== 3'b001 || RegWriteE !== 1'b1 || RdE !== 5'd3) begin
      errors++; $display("FAIL wt_sub_ctrl got=%b/%b/%0d want=001/1/3", ALUControlE, RegWriteE, RdE);
    end
    // x0 write attempt, reading x0 on both ports
    RDW = 5'd0; ResultW = 32'hDEAD; InstrD = 32'h00000033;
    tick();
    checks++;
    if (RD1E !== 32'd0 || RD2E !== 32'd0) begin
      errors++; $display("FAIL x0_same_cycle got=%h/%h want=0/0", RD1E, RD2E);
    end
    RegWriteW = 1'b0;
    tick();
    checks++;
    if (RD1E !== 32'd0) begin errors++; $display("FAIL x0_after got=%h want=0", RD1E); end
  endtask

  task automatic test_store_branch();
    InstrD = 32'h0020A423;
    tick();
    checks++;
    if (MemWriteE !== 1'b1 || RegWriteE !== 1'b0 || ALUSrcE !== 1'b1 || ImmExtE !== 32'd8) begin
      errors++; $display("FAIL sw got=%b/%b/%b/%h want=1/0/1/8", MemWriteE, RegWriteE, ALUSrcE, ImmExtE);
    end
    checks++;
    if (RD1E !== 32'd5 || RD2E !== 32'd7) begin
      errors++; $display("FAIL sw_operands got=%0d/%0d want=5/7", RD1E, RD2E);
    end
    InstrD = 32'hFE208EE3;
    tick();
    checks++;
    if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || ImmExtE !== 32'hFFFFFFFC || RegWriteE !== 1'b0) begin
      errors++; $display("FAIL beq got=%b/%b/%h/%b want=1/001/fffffffc/0", BranchE, ALUControlE, ImmExtE, RegWriteE);
    end
  endtask

  task automatic test_jump();
    InstrD = 32'h008000EF;
    tick();
    checks++;
    if (JumpE !== 1'b1 || ResultSrcE !== 2'b10 || ImmExtE !== 32'd8 || RdE !== 5'd1 || RegWriteE !== 1'b1) begin
      errors++; $display("FAIL jal got=%b/%b/%h/%0d/%b want=1/10/8/1/1", JumpE, ResultSrcE, ImmExtE, RdE, RegWriteE);
    end
  endtask

  task automatic test_flush_illegal();
    InstrD = 32'h00208233; PCD = 32'h40; PcPlus4D = 32'h44;
    FlushE = 1'b1; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'h55;
    tick();
    checks++;
    if (all_e !== '0) begin errors++; $display("FAIL flush_bubble got=%h want=0", all_e); end
    FlushE = 1'b0; RegWriteW = 1'b0; InstrD = 32'h00028033;
    tick();
    checks++;
    if (RD1E !== 32'h55) begin errors++; $display("FAIL flush_write_kept got=%h want=55", RD1E); end
    InstrD = 32'hFFFFFFFF;
    tick();
    checks++;
    if (ctrl_e !== '0) begin errors++; $display("FAIL illegal_ctrl got=%b want=0", ctrl_e); end
    checks++;
    if (RdE !== 5'd31 || Rs1E !== 5'd31 || Rs2E !== 5'd31) begin
      errors++; $display("FAIL illegal_fields got=%0d/%0d/%0d want=31/31/31", RdE, Rs1E, Rs2E);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] r;
    InstrD = 32'h00500093; PCD = 32'h80; PcPlus4D = 32'h84;
    tick();
    RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h66;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_e !== '0) begin errors++; $display("FAIL reset_async got=%h want=0", all_e); end
    tick();
    RegWriteW = 1'b0;
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      r = 5'(i);
      InstrD = {7'b0, r, r, 3'b000, 5'd0, 7'b0110011};
      tick();
      checks++;
      if (RD1E !== 32'd0 || RD2E !== 32'd0) begin
        errors++; $display("FAIL reset_regclear x%0d got=%h/%h want=0/0", i, RD1E, RD2E);
      end
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_write_through();
    test_store_branch();
    test_jump();
    test_flush_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RISC-V pipeline, and the consumer of the IF/ID register produced by the fetch stage. It decodes `InstrD` into control signals and a sign-extended immediate, and reads two operands from the 32×32 register file, which it owns. It accepts write-back from the W stage and registers everything into the ID/EX pipeline register for the execute stage, with a synchronous bubble-insert (flush) path.

## Interface
- No parameters. Fixed at XLEN = 32 and 32 registers.
- `clk` in 1: single clock. All state updates on the posedge.
- `rst` in 1: asynchronous, active-high reset.
- `InstrD` in 32: instruction from the IF/ID register.
- `PCD` in 32: PC of `InstrD`.
- `PcPlus4D` in 32: `PCD` + 4.
- `RegWriteW` in 1: write-back enable.
- `RDW` in 5: write-back destination register.
- `ResultW` in 32: write-back data.
- `FlushE` in 1: load a bubble into ID/EX on the next edge.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE` out 1 each: registered control signals.
- `ResultSrcE` out 2: result select. 00 = ALU, 01 = memory, 10 = PC+4.
- `ALUControlE` out 3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RD1E`, `RD2E` out 32: registered register-file read data.
- `ImmExtE` out 32: registered sign-extended immediate.
- `Rs1E`, `Rs2E`, `RdE` out 5: registered `InstrD[19:15]`, `[24:20]`, `[11:7]`.
- `PCE`, `PcPlus4E` out 32: registered `PCD` and `PcPlus4D`.

## Operation
- **Main decoder**, keyed on `op = InstrD[6:0]`:
  - lw 0000011: RegWrite=1, ImmSrc=I, ALUSrc=1, ResultSrc=01, ALUOp=00.
  - sw 0100011: MemWrite=1, ImmSrc=S, ALUSrc=1, ALUOp=00.
  - R-type 0110011: RegWrite=1, ALUOp=10.
  - beq 1100011: Branch=1, ImmSrc=B, ALUOp=01.
  - I-ALU 0010011: RegWrite=1, ImmSrc=I, ALUSrc=1, ALUOp=10.
  - jal 1101111: RegWrite=1, Jump=1, ImmSrc=J, ResultSrc=10.
  - Any other opcode: every control output is 0, i.e. a bubble. Rs/Rd/PC fields still pass through.
- **ALU decoder**:
  - ALUOp 00 → add. ALUOp 01 → sub.
  - ALUOp 10, by funct3: 000 → sub only when op[5]=1 and funct7[5]=1, otherwise add; 010 → slt; 110 → or; 111 → and.
  - Any other funct3 → add.
- **Immediate generation**, all results sign-extended from `InstrD[31]`:
  - I: `[31:20]`.
  - S: `{[31:25],[11:7]}`.
  - B: `{[31],[7],[30:25],[11:8],0}`.
  - J: `{[31],[19:12],[20],[30:21],0}`.
- **Register file**:
  - x0 reads as 0 and is never written.
  - Write at posedge when `RegWriteW`=1 and `RDW`≠0.
  - Reads are combinational with write-through: if `RegWriteW`=1, `RDW`≠0 and `RDW` equals the read index, the read returns `ResultW` in the same cycle.
  - `rst` clears all 31 registers to 0.
- **ID/EX register**:
  - Captures the decoded values every posedge. There is no stall input.
  - `FlushE`=1 at an edge loads all ID/EX outputs with 0, including data fields.
  - Reset has priority over `FlushE`. `FlushE` has priority over normal capture.

## Timing
- Latency is 1 cycle: `InstrD`/`PCD` presented before edge N appear on the E outputs after edge N.
- Decode, immediate generation and register read are purely combinational within the cycle.
- Reset: every output is 0 (an all-zero ID/EX is a bubble). Register contents are 0.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous), and any register write in that cycle is lost.
- First edge after `rst` falls: normal capture.
- Same-cycle write and read of the same register: the new value is captured into `RD1E`/`RD2E` at that edge.
- `RegWriteW` with `RDW`=0: no effect, and reads of x0 stay 0.
- `FlushE` and a W-stage write on the same edge: the register-file write still occurs, and ID/EX becomes a bubble.

## Test plan
- **Reset:** assert `rst` mid-run → all E outputs 0 asynchronously. After release, reading x1–x31 returns 0.
- **I-type:** `InstrD`=0x00500093 (addi x1,x0,5), `PCD`=0x10 → after one edge: `RegWriteE`=1, `ALUSrcE`=1, `ImmExtE`=5, `RdE`=1, `ALUControlE`=000, `PCE`=0x10, `PcPlus4E`=0x14.
- **Write-through and x0 protection:**
  - `RegWriteW`=1, `RDW`=1, `ResultW`=5, `RDW`=2, `ResultW`=7 on successive cycles, with 0x402081B3 (sub x3,x1,x2) in decode on the second write cycle → `RD1E`=5, `RD2E`=7, `ALUControlE`=001.
  - A write to x0 leaves x0 reading 0.
- **Store and branch immediates:**
  - 0x0020A423 (sw x2,8(x1)) → `MemWriteE`=1, `RegWriteE`=0, `ImmExtE`=8.
  - 0xFE208EE3 (beq x1,x2,-4) → `BranchE`=1, `ALUControlE`=001, `ImmExtE`=0xFFFFFFFC.
- **Jump:** 0x008000EF (jal x1,8) → `JumpE`=1, `ResultSrcE`=10, `ImmExtE`=8, `RdE`=1.
- **Flush and illegal opcode:**
  - `FlushE`=1 with a valid add in decode → all E outputs 0 for that cycle, and the concurrent W write is still visible on a later read.
  - `InstrD`=0xFFFFFFFF → all control outputs 0.
